score_award_sequencer: RTL and testbench
========================================

// Module: score_award_sequencer
// PURPOSE
//  Initiator side of the score-counter enable/ready handshake. Game logic posts
//  multi-point awards; this block queues them in a saturating pending counter and
//  issues one-cycle score_enable pulses to the BCD score counter, one per point,
//  each paced by the counter's ready. Sits between game FSM and score/display path.
// PARAMETERS
//  POINT_WIDTH    4     width of award_points (max single award 2^POINT_WIDTH-1)
//  MAX_PENDING    255   saturation limit of pending point count
//  PENDING_WIDTH  $clog2(MAX_PENDING+1)  width of pending_count (derived)
// PORTS
//  clock          in   1              system clock; all logic rising-edge
//  reset          in   1              synchronous, active-high
//  award_valid    in   1              award strobe, sampled every cycle
//  award_points   in   POINT_WIDTH    points in this award (0 = no-op)
//  score_ready    in   1              counter ready for next increment
//  score_enable   out  1              one-cycle increment pulse to counter
//  pending_count  out  PENDING_WIDTH  points accepted, not yet issued
//  busy           out  1              high when pending_count!=0 or state!=IDLE
//  award_overflow out  1              sticky saturation flag (only with macro)
// BEHAVIOUR
//  Reset (sync, active-high): state=IDLE, pending_count=0, score_enable=0, busy=0,
//   award_overflow=0. Reset mid-handshake abandons the pulse and clears pending.
//  Reset dominates all other inputs in the same cycle.
//  FSM, registered outputs:
//   IDLE : pending_count!=0 && score_ready -> PULSE next cycle.
//   PULSE: score_enable=1 for exactly this cycle; pending decrements by 1 at
//          this edge; always -> GUARD.
//   GUARD: one dead cycle, score_ready ignored (covers counter ready-drop
//          latency); always -> WAIT.
//   WAIT : score_ready=1 -> IDLE; else stay.
//  Min spacing between score_enable pulses = 4 cycles; never back-to-back.
//  Pending update each cycle: next = pending + (award_valid ? award_points : 0)
//   - (state==PULSE ? 1 : 0); computed at PENDING_WIDTH+1 bits, clipped to
//   MAX_PENDING. Simultaneous award and decrement both apply in that cycle.
//  award_points=0 with award_valid=1: no change, no pulse.
//  pending_count never underflows (decrement only issued when pending!=0).
//  score_ready low in IDLE: hold, pending keeps accumulating.
//  Latency: award in IDLE with score_ready=1 -> score_enable 2 cycles later.
// CONFIGURATION
//  AWARD_OVERFLOW_FLAG_EN defined: award_overflow sets when unclipped next >
//   MAX_PENDING; stays set until reset.
//  Not defined: award_overflow tied 0; saturation still applied silently.
// STRUCTURE
//  score_pkg: FSM state localparams (IDLE/PULSE/GUARD/WAIT, 2-bit encoding),
//   MIN_PULSE_SPACING=4, shared with BCD counter/score path.
//  Sub-module pending_accumulator: saturating add/decrement register, plus
//   overflow detect; top holds FSM and output registers.
// TESTING
//  1 reset; award 3 pts, score_ready=1 -> 3 enable pulses 4 cycles apart;
//    pending 3->2->1->0; busy low after last WAIT exits.
//  2 score_ready held 0, award 5 -> no pulse, pending=5; release ready ->
//    first pulse 1 cycle after IDLE sees ready.
//  3 pending=2, award 4 in PULSE cycle -> pending=5 next cycle (2+4-1).
//  4 MAX_PENDING=255, pending=250, award 15 -> pending=255; award_overflow=1
//    with macro, 0 without; stays 1 after pending drains.
//  5 reset asserted in PULSE, pending=7 -> next cycle enable=0, pending=0,
//    state IDLE, overflow cleared.
//  6 award_valid=1, points=0 repeatedly from IDLE/pending=0 -> no pulses, busy=0.

Source files
------------

// File: rtl/score_pkg.sv
// Shared definitions for the score path: sequencer FSM encoding and pulse pacing.
package score_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GUARD = 2'd2,
        WAIT  = 2'd3
    } seq_state_t;

    localparam int MIN_PULSE_SPACING = 4;

endpackage

// File: rtl/pending_accumulator.sv
// Saturating pending-point register: adds awarded points, removes one per issued pulse.
// Optional sticky saturation flag under AWARD_OVERFLOW_FLAG_EN.
module pending_accumulator #(
    parameter int POINT_WIDTH   = 4,
    parameter int MAX_PENDING   = 255,
    parameter int PENDING_WIDTH = $clog2(MAX_PENDING + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     add_valid,
    input  logic [POINT_WIDTH-1:0]   add_points,
    input  logic                     dec,
    output logic [PENDING_WIDTH-1:0] count,
    output logic                     overflow
);

    localparam int SW = PENDING_WIDTH + 1;

    logic [SW-1:0]            add_ext;
    logic [SW-1:0]            dec_ext;
    logic [SW-1:0]            sum;
    logic                     over;
    logic [PENDING_WIDTH-1:0] count_d;

    // One extra bit of headroom so a full-scale award on a full counter is still visible.
    always_comb begin
        add_ext = '0;
        dec_ext = '0;
        if (add_valid) add_ext = SW'(add_points);
        if (dec && (count != '0)) dec_ext = SW'(1);
        sum     = {1'b0, count} + add_ext - dec_ext;
        over    = (sum > SW'(MAX_PENDING));
        count_d = over ? PENDING_WIDTH'(MAX_PENDING) : sum[PENDING_WIDTH-1:0];
    end

    always_ff @(posedge clock) begin
        if (reset) count <= '0;
        else       count <= count_d;
    end

`ifdef AWARD_OVERFLOW_FLAG_EN
    always_ff @(posedge clock) begin
        if (reset)     overflow <= 1'b0;
        else if (over) overflow <= 1'b1;
    end
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: rtl/score_award_sequencer.sv
// Queues multi-point awards and issues paced one-point score_enable pulses to the counter.
// Optional sticky award_overflow flag under AWARD_OVERFLOW_FLAG_EN.
module score_award_sequencer
    import score_pkg::*;
#(
    parameter int POINT_WIDTH   = 4,
    parameter int MAX_PENDING   = 255,
    parameter int PENDING_WIDTH = $clog2(MAX_PENDING + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     award_valid,
    input  logic [POINT_WIDTH-1:0]   award_points,
    input  logic                     score_ready,
    output logic                     score_enable,
    output logic [PENDING_WIDTH-1:0] pending_count,
    output logic                     busy,
    output logic                     award_overflow,
    output logic [1:0]               state
);

    // Handshake: score_enable is a single-cycle request; the counter answers by
    // dropping score_ready and raising it again when it can take the next point.
    seq_state_t state_q, state_d;
    logic       enable_q;

    pending_accumulator #(
        .POINT_WIDTH  (POINT_WIDTH),
        .MAX_PENDING  (MAX_PENDING),
        .PENDING_WIDTH(PENDING_WIDTH)
    ) u_acc (
        .clock     (clock),
        .reset     (reset),
        .add_valid (award_valid),
        .add_points(award_points),
        .dec       (state_q == PULSE),
        .count     (pending_count),
        .overflow  (award_overflow)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            enable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            enable_q <= (state_d == PULSE);
        end
    end

    // GUARD is a dead cycle so a slow ready-drop from the counter is never mistaken for ready.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if ((pending_count != '0) && score_ready) state_d = PULSE;
            PULSE:   state_d = GUARD;
            GUARD:   state_d = WAIT;
            WAIT:    if (score_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign score_enable = enable_q;
    assign busy         = (pending_count != '0) || (state_q != IDLE);
    assign state        = state_q;

endmodule

// File: tb/tb_score_award_sequencer.sv
// Bench for score_award_sequencer: cycle vector table, saturation/drain sequence, random scoreboard run.
module tb_score_award_sequencer;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PULSE = 2'd1;
    localparam logic [1:0] S_GUARD = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;
`ifdef AWARD_OVERFLOW_FLAG_EN
    localparam logic EXP_OVF = 1'b1;
`else
    localparam logic EXP_OVF = 1'b0;
`endif

    logic       clock;
    logic       reset;
    logic       award_valid;
    logic [3:0] award_points;
    logic       score_ready;
    logic       score_enable;
    logic [7:0] pending_count;
    logic       busy;
    logic       award_overflow;
    logic [1:0] state;

    int total;
    int bad;

    typedef struct {
        logic       rst;
        logic       av;
        logic [3:0] pts;
        logic       rdy;
        logic       en;
        logic [7:0] pend;
        logic       bsy;
        logic [1:0] st;
    } vec_t;

    vec_t       vq[$];
    logic [7:0] exp_q[$];

    score_award_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .award_valid   (award_valid),
        .award_points  (award_points),
        .score_ready   (score_ready),
        .score_enable  (score_enable),
        .pending_count (pending_count),
        .busy          (busy),
        .award_overflow(award_overflow),
        .state         (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic av, input logic [3:0] pts, input logic rdy);
        reset        = r;
        award_valid  = av;
        award_points = pts;
        score_ready  = rdy;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic add(input logic r, input logic av, input logic [3:0] pts, input logic rdy,
                       input logic en, input logic [7:0] pend, input logic bsy, input logic [1:0] st);
        vec_t v;
        v.rst = r; v.av = av; v.pts = pts; v.rdy = rdy;
        v.en = en; v.pend = pend; v.bsy = bsy; v.st = st;
        vq.push_back(v);
    endtask

    initial begin
        int pulses;
        int last_pulse;
        int cyc;
        logic done;

        total = 0;
        bad   = 0;
        drive(1'b1, 1'b0, 4'd0, 1'b0);
        #2;

        // reset; award 3 with ready high -> pulses every 4 cycles, pending 3->0
        add(1,0,0,0, 0,0,0,S_IDLE);
        add(0,1,3,1, 0,3,1,S_IDLE);
        add(0,0,0,1, 1,3,1,S_PULSE);
        add(0,0,0,1, 0,2,1,S_GUARD);
        add(0,0,0,1, 0,2,1,S_WAIT);
        add(0,0,0,1, 0,2,1,S_IDLE);
        add(0,0,0,1, 1,2,1,S_PULSE);
        add(0,0,0,1, 0,1,1,S_GUARD);
        add(0,0,0,1, 0,1,1,S_WAIT);
        add(0,0,0,1, 0,1,1,S_IDLE);
        add(0,0,0,1, 1,1,1,S_PULSE);
        add(0,0,0,1, 0,0,1,S_GUARD);
        add(0,0,0,1, 0,0,1,S_WAIT);
        add(0,0,0,1, 0,0,0,S_IDLE);
        // ready held low while 5 points are posted, then released
        add(0,1,5,0, 0,5,1,S_IDLE);
        add(0,0,0,0, 0,5,1,S_IDLE);
        add(0,0,0,0, 0,5,1,S_IDLE);
        add(0,0,0,1, 1,5,1,S_PULSE);
        add(0,0,0,1, 0,4,1,S_GUARD);
        add(0,0,0,1, 0,4,1,S_WAIT);
        add(0,0,0,1, 0,4,1,S_IDLE);
        add(0,0,0,1, 1,4,1,S_PULSE);
        add(0,0,0,1, 0,3,1,S_GUARD);
        add(0,0,0,1, 0,3,1,S_WAIT);
        add(0,0,0,1, 0,3,1,S_IDLE);
        add(0,0,0,1, 1,3,1,S_PULSE);
        add(0,0,0,1, 0,2,1,S_GUARD);
        add(0,0,0,1, 0,2,1,S_WAIT);
        add(0,0,0,1, 0,2,1,S_IDLE);
        add(0,0,0,1, 1,2,1,S_PULSE);
        // award in the PULSE cycle: 2 + 4 - 1; ready low is ignored in GUARD
        add(0,1,4,0, 0,5,1,S_GUARD);
        add(0,0,0,0, 0,5,1,S_WAIT);
        add(0,0,0,0, 0,5,1,S_WAIT);
        add(0,0,0,1, 0,5,1,S_IDLE);
        add(1,0,0,1, 0,0,0,S_IDLE);
        // reset during PULSE with pending 7, award in the same cycle is dropped
        add(0,1,7,1, 0,7,1,S_IDLE);
        add(0,0,0,1, 1,7,1,S_PULSE);
        add(1,1,9,1, 0,0,0,S_IDLE);
        add(0,0,0,1, 0,0,0,S_IDLE);
        // zero-point awards are no-ops
        add(0,1,0,1, 0,0,0,S_IDLE);
        add(0,1,0,1, 0,0,0,S_IDLE);
        add(0,1,0,1, 0,0,0,S_IDLE);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].av, vq[i].pts, vq[i].rdy);
            step();
            chk($sformatf("vec%0d enable", i),  32'(score_enable),  32'(vq[i].en));
            chk($sformatf("vec%0d pending", i), 32'(pending_count), 32'(vq[i].pend));
            chk($sformatf("vec%0d busy", i),    32'(busy),          32'(vq[i].bsy));
            chk($sformatf("vec%0d state", i),   32'(state),         32'(vq[i].st));
            chk($sformatf("vec%0d overflow", i), 32'(award_overflow), 32'(1'b0));
        end

        // saturation: climb to 250, overshoot to 255, then drain
        drive(1'b1, 1'b0, 4'd0, 1'b0);
        step();
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 4'd15, 1'b0);
            step();
        end
        drive(1'b0, 1'b1, 4'd10, 1'b0);
        step();
        chk("sat pending 250", 32'(pending_count), 32'd250);
        chk("sat no overflow yet", 32'(award_overflow), 32'(1'b0));
        drive(1'b0, 1'b1, 4'd15, 1'b0);
        step();
        chk("sat pending clipped", 32'(pending_count), 32'd255);
        chk("sat overflow set", 32'(award_overflow), 32'(EXP_OVF));
        step();
        chk("sat pending held", 32'(pending_count), 32'd255);
        drive(1'b0, 1'b0, 4'd0, 1'b1);
        pulses = 0;
        done   = 1'b0;
        for (int i = 0; i < 1200 && !done; i++) begin
            step();
            if (score_enable) pulses++;
            if (pending_count == 8'd0 && !busy) done = 1'b1;
        end
        chk("drain finished", 32'(done), 32'd1);
        chk("drain pulse count", 32'(pulses), 32'd255);
        chk("overflow sticky after drain", 32'(award_overflow), 32'(EXP_OVF));
        drive(1'b1, 1'b0, 4'd0, 1'b1);
        step();
        chk("overflow cleared by reset", 32'(award_overflow), 32'(1'b0));
        chk("pending cleared by reset", 32'(pending_count), 32'd0);

        // random run against the point scoreboard
        drive(1'b0, 1'b0, 4'd0, 1'b1);
        last_pulse = -100;
        cyc        = 0;
        done       = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            chk("sb pending", 32'(pending_count), 32'(exp_q.size()));
            if (score_enable) begin
                chk("sb pulse owed", 32'(exp_q.size() != 0), 32'd1);
                chk("sb pulse spacing", 32'(cyc - last_pulse >= 4), 32'd1);
                last_pulse = cyc;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (i < 400) begin
                drive(1'b0, ($urandom_range(0, 31) == 0), 4'($urandom_range(0, 3)),
                      ($urandom_range(0, 3) != 0));
                if (award_valid)
                    for (int k = 0; k < int'(award_points); k++) exp_q.push_back(8'(i));
            end else begin
                drive(1'b0, 1'b0, 4'd0, 1'b1);
                if (exp_q.size() == 0 && !busy) done = 1'b1;
            end
            step();
            cyc++;
        end
        chk("sb drained", 32'(exp_q.size()), 32'd0);
        chk("sb idle at end", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
